nbit_reg: RTL and testbench
===========================

Name: nbit_reg

Overview:
Generic n-bit clocked storage register with write enable and global write enable. Used throughout the datapath, e.g. the memory block's time-multiplexed read-port latches (16-bit, reset value 0). Purely sequential; no combinational path from in to out.

Parameters:
n, 1, data width in bits (positional parameter 1).
r, 0 (n bits), value loaded on reset (positional parameter 2; e.g. #(16, 16'd0)).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-low reset; sampled only on rising clk.
in  input  n  data to store.
out  output  n  current stored value (register output).
we  input  1  local write enable, active-high.
gwe  input  1  global write enable, active-high; ANDed with we.

Behaviour:
- Single state register of n bits; out is driven directly from it.
- Each rising clk edge, in priority order:
  1. rst == 0 -> state <= r. Reset wins over any we/gwe/in value.
  2. else if we == 1 and gwe == 1 -> state <= in.
  3. else -> state holds.
- Latency: a write at edge k is visible on out immediately after edge k (1-cycle write-to-read). in changing between edges never affects out.
- Reset is synchronous. Asserting rst between edges does not change out until the next rising edge. Deasserting rst mid-stream resumes normal write/hold behaviour on the first edge where rst == 1.
- Power-up/simulation initial value of state = r, so out is defined before the first reset.
- gwe == 0 blocks all writes regardless of we; reset is still honoured while gwe == 0.
- No width conversion: in, out and r are exactly n bits. All bits are written together; there are no per-bit enables.
- X/Z on we or gwe while rst == 1: no requirement beyond standard simulator semantics.
- Must be synthesizable as n flip-flops with synchronous reset and a clock-enable equal to we & gwe.

Test Plan:
- Reset: n=16, r=16'h0000, rst=0 for one edge with we=gwe=1, in=16'hBEEF -> out=16'h0000 after the edge (reset priority).
- Write: rst=1, we=1, gwe=1, in=16'h1234 at edge -> out=16'h1234. Then in=16'h5678 with we=0 -> out stays 16'h1234 after the edge.
- Global enable: rst=1, we=1, gwe=0, in=16'hAAAA -> out unchanged. Set gwe=1 -> out=16'hAAAA after the next edge.
- Sync reset timing: out=16'h1234; drop rst mid-cycle -> out still 16'h1234 until the next rising edge, then 16'h0000. Raise rst with in=16'h00FF, we=gwe=1 -> out=16'h00FF after the following edge.
- Non-zero reset value: n=8, r=8'hA5; write 8'h3C, then rst=0 for one edge -> out=8'hA5. Also check out=8'hA5 at time 0 before any edge.
- Width 1: n=1, r=1; toggle in every cycle with we=gwe=1 -> out follows in with exactly one-edge delay.

Source files
------------

// File: rtl/nbit_reg.sv
// Generic n-bit storage register with synchronous active-low reset to a
// parameterised value and a clock enable formed from local and global enables.
module nbit_reg #(
    parameter int unsigned  n = 1,
    parameter logic [n-1:0] r = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] in,
    output logic [n-1:0] out,
    input  logic         we,
    input  logic         gwe
);

    // Declaration initialiser gives a defined power-up value equal to r.
    logic [n-1:0] state_p0 = r;
    logic         wr_en;

    assign wr_en = we & gwe;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_p0 <= r;
        end else if (wr_en) begin
            state_p0 <= in;
        end
    end

    assign out = state_p0;

endmodule

// File: tb/tb_nbit_reg.sv
// Directed and randomized checks of nbit_reg at widths 16, 8 and 1 against a
// behavioural next-value model.
module tb_nbit_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic        gwe = 1'b0;
    logic [15:0] in16 = '0;
    logic [7:0]  in8  = '0;
    logic        in1  = 1'b0;
    logic [15:0] out16;
    logic [7:0]  out8;
    logic        out1;

    int checks = 0;
    int errors = 0;

    logic [15:0] m16 = 16'h0000;
    logic [7:0]  m8  = 8'hA5;
    logic        m1  = 1'b1;

    always #5 clk = ~clk;

    nbit_reg #(16, 16'h0000) u16 (.clk(clk), .rst(rst), .in(in16), .out(out16), .we(we), .gwe(gwe));
    nbit_reg #(8,  8'hA5)    u8  (.clk(clk), .rst(rst), .in(in8),  .out(out8),  .we(we), .gwe(gwe));
    nbit_reg #(1,  1'b1)     u1  (.clk(clk), .rst(rst), .in(in1),  .out(out1),  .we(we), .gwe(gwe));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one rising edge: the model computes the stored value from the
    // inputs present at the edge, then all outputs are compared after it.
    task automatic tick(input string tag);
        if (rst === 1'b0) begin
            m16 = 16'h0000;
            m8  = 8'hA5;
            m1  = 1'b1;
        end else if (we === 1'b1 && gwe === 1'b1) begin
            m16 = in16;
            m8  = in8;
            m1  = in1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_o16"}, out16, m16);
        chk({tag, "_o8"}, {8'h00, out8}, {8'h00, m8});
        chk({tag, "_o1"}, {15'h0, out1}, {15'h0, m1});
    endtask

    initial begin
        #1;
        chk("init_o16", out16, 16'h0000);
        chk("init_o8", {8'h00, out8}, 16'h00A5);
        chk("init_o1", {15'h0, out1}, 16'h0001);

        // Reset wins over an active write.
        rst = 1'b0; we = 1'b1; gwe = 1'b1; in16 = 16'hBEEF; in8 = 8'h3C; in1 = 1'b0;
        tick("rst_prio");

        rst = 1'b1; in16 = 16'h1234; in8 = 8'h3C;
        tick("write");
        we = 1'b0; in16 = 16'h5678; in8 = 8'h11;
        tick("hold_we0");

        we = 1'b1; gwe = 1'b0; in16 = 16'hAAAA; in8 = 8'h55;
        tick("gwe_block");
        gwe = 1'b1;
        tick("gwe_open");

        in16 = 16'h1234; in8 = 8'h3C;
        tick("pre_sync");
        // Mid-cycle reset assertion must not disturb out before the edge.
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_o16", out16, 16'h1234);
        chk("rst_mid_o8", {8'h00, out8}, 16'h003C);
        tick("sync_rst");
        rst = 1'b1; in16 = 16'h00FF; in8 = 8'h0F;
        tick("rst_release");

        // Mid-cycle input change must not reach out before the edge.
        #2;
        in16 = 16'hDEAD;
        #1;
        chk("in_mid_o16", out16, 16'h00FF);
        tick("in_mid_edge");

        gwe = 1'b0; rst = 1'b0;
        tick("rst_gwe0");
        gwe = 1'b1; rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            in1 = ~in1;
            tick("toggle1");
        end

        for (int i = 0; i < 300; i++) begin
            rst  = ($urandom_range(0, 19) != 0);
            we   = $urandom_range(0, 3) != 0;
            gwe  = $urandom_range(0, 3) != 0;
            in16 = 16'($urandom);
            in8  = 8'($urandom);
            in1  = 1'($urandom);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
